dmem_responder: RTL and testbench

- Responder side of the CPU data-memory interface: accepts load/store requests from the pipeline's memory stage and answers after a fixed, parameterised latency.
- Sits between the CPU datapath and a word-organised data store.
- Replaces the zero-latency combinational model so the CPU's stall/handshake logic can be exercised against a realistic slave.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e      : handshake FSM states
//   MAX_LATENCY  : largest supported response latency
//   CNT_W        : width of the latency down-counter
//   addr_err()   : address legality check (alignment and window bounds)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  // Flags an access that is misaligned, below the window base, or past the
  // last word. The word offset is a plain 32-bit unsigned subtraction, so an
  // address below the base becomes a huge offset and can never alias.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] word_off;
    word_off = (addr - base) >> 2;
    return (addr[1:0] != 2'b00) || (addr < base) || (word_off >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised single-port RAM with byte-lane write enables.
//   clk_i    : clock, rising edge
//   en_i     : access enable; read and optional write happen at the edge
//   we_i     : per-byte write enables, we_i[0] covers bits 7:0
//   addr_i   : word index
//   wdata_i  : write data
//   rdata_o  : registered read data; a write returns the word's old value
// Contents have no reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder side of the CPU data-memory interface. Accepts one load/store,
// answers LATENCY cycles later with a single-cycle ack, then may accept the
// next request in the ack cycle itself.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous reset, active low
//   req_i    : request strobe, ignored while busy_o=1
//   we_i     : 1 = store, 0 = load
//   addr_i   : byte address
//   wdata_i  : store data
//   be_i     : store byte-lane enables
//   ack_o    : one-cycle completion pulse
//   rdata_o  : load data, held until the next ack
//   err_o    : access rejected, meaningful only with ack_o
//   busy_o   : request in flight
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int              AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_latency_check
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q;
  logic             err_q;
  logic             rsel_q;   // 1: rdata_o follows the RAM read register
  logic [31:0]      rdata_q;  // held value when rdata_o does not follow the RAM

  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             in_wait;
  logic             accept;
  logic             commit;
  logic             c_we;
  logic [31:0]      c_addr;
  logic [31:0]      c_wdata;
  logic [3:0]       c_be;
  logic             c_err;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_rdata;
  logic [31:0]      rdata_cur;

  assign in_wait = (state_q == WAIT);
  assign accept  = req_i && !in_wait;

  // The memory access happens at the edge that enters RESP. With LATENCY=1
  // that is the accepting edge itself, so the live inputs are used; otherwise
  // it is the last WAIT edge and the latched request is used.
  assign commit = in_wait ? (cnt_q == CNT_W'(1)) : (accept && (LATENCY == 1));

  always_comb begin
    if (in_wait) begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end else begin
      c_we    = we_i;
      c_addr  = addr_i;
      c_wdata = wdata_i;
      c_be    = be_i;
    end
  end

  assign c_err    = addr_err(c_addr, BASE_ADDR, 32'(DEPTH_WORDS));
  // Gated by reset so nothing is written while the block is held in reset.
  assign ram_en   = commit && !c_err && rst_i;
  assign ram_we   = c_we ? c_be : 4'b0000;
  assign ram_addr = AW'((c_addr - BASE_ADDR) >> 2);

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (c_wdata),
    .rdata_o (ram_rdata)
  );

  assign rdata_cur = rsel_q ? ram_rdata : rdata_q;

  // Request capture: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      be_q    <= be_i;
    end
  end

  // Handshake FSM and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= commit;
      err_q <= commit && c_err;

      if (commit) begin
        if (c_err) begin
          rsel_q  <= 1'b0;
          rdata_q <= '0;
        end else if (c_we) begin
          // The RAM read register picks up the stored word's old value on a
          // write, so freeze the currently visible load data instead.
          rsel_q  <= 1'b0;
          rdata_q <= rdata_cur;
        end else begin
          rsel_q  <= 1'b1;
        end
      end

      unique case (state_q)
        IDLE, RESP: begin
          if (req_i) begin
            cnt_q   <= CNT_LOAD;
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_cur;
  assign busy_o  = in_wait;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=3 and base 0, one with
// LATENCY=1 and base 0x1000, sharing clock and reset.
module tb_dmem_responder;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_req, a_we, a_ack, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        b_req, b_we, b_ack, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .BASE_ADDR(32'h0000_0000)) u_a (
    .clk_i(clk), .rst_i(rst_n), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .be_i(a_be), .ack_o(a_ack), .rdata_o(a_rdata),
    .err_o(a_err), .busy_o(a_busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B), .BASE_ADDR(32'h0000_1000)) u_b (
    .clk_i(clk), .rst_i(rst_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .be_i(b_be), .ack_o(b_ack), .rdata_o(b_rdata),
    .err_o(b_err), .busy_o(b_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-instance word store, validity flags and the load
  // data the responder should currently be presenting.
  logic [31:0] mdl_mem   [2][DEPTH];
  bit          mdl_known [2][DEPTH];
  logic [31:0] mdl_rd    [2];
  bit          mdl_rdk   [2];

  typedef struct {
    bit          sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rd);
    vec_t v;
    v.sel = sel; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_err = exp_err; v.exp_rd = exp_rd;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (sel) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    end
  endtask

  // Issues one request and waits (bounded) for its ack. lat is the ack cycle
  // counted from the cycle in which req was presented; -1 if it never came.
  task automatic txn(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic err, output logic [31:0] rd, output int lat);
    drive(sel, 1'b1, we, addr, wdata, be);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    lat = -1; err = 1'b0; rd = 32'h0;
    for (int k = 0; k < 20; k++) begin
      if (sel ? b_ack : a_ack) begin
        lat = k + 1;
        err = sel ? b_err : a_err;
        rd  = sel ? b_rdata : a_rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic model_step(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic e_err, output logic [31:0] e_rd, output bit e_k);
    longint unsigned a, base;
    int idx;
    a    = 64'(addr);
    base = sel ? 64'h1000 : 64'h0;
    if ((a % 4 != 0) || (a < base) || (a >= base + 4 * DEPTH)) begin
      e_err = 1'b1;
      mdl_rd[sel]  = 32'h0;
      mdl_rdk[sel] = 1'b1;
    end else begin
      e_err = 1'b0;
      idx = int'((a - base) / 4);
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl_mem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        if (be == 4'hF) mdl_known[sel][idx] = 1'b1;
      end else begin
        mdl_rd[sel]  = mdl_mem[sel][idx];
        mdl_rdk[sel] = mdl_known[sel][idx];
      end
    end
    e_rd = mdl_rd[sel];
    e_k  = mdl_rdk[sel];
  endtask

  task automatic run_model(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input string tag);
    logic err, e_err;
    logic [31:0] rd, e_rd;
    int lat;
    bit e_k;
    txn(sel, we, addr, wdata, be, err, rd, lat);
    model_step(sel, we, addr, wdata, be, e_err, e_rd, e_k);
    check({tag, "_lat"}, lat, sel ? LAT_B : LAT_A);
    check({tag, "_err"}, {31'b0, err}, {31'b0, e_err});
    if (e_k) check({tag, "_rdata"}, rd, e_rd);
  endtask

  task automatic model_reset();
    mdl_rd[0] = 32'h0; mdl_rd[1] = 32'h0;
    mdl_rdk[0] = 1'b1; mdl_rdk[1] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic err;
    logic [31:0] rd;
    int lat;
    logic e_err;
    logic [31:0] e_rd;
    bit e_k;
    int ack_k[$];
    logic [31:0] ack_d[$];
    int nacks;

    for (int s = 0; s < 2; s++) for (int i = 0; i < DEPTH; i++) mdl_known[s][i] = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ack",   {31'b0, a_ack},  32'h0);
    check("rst_a_err",   {31'b0, a_err},  32'h0);
    check("rst_a_busy",  {31'b0, a_busy}, 32'h0);
    check("rst_a_rdata", a_rdata,         32'h0);
    check("rst_b_ack",   {31'b0, b_ack},  32'h0);
    check("rst_b_err",   {31'b0, b_err},  32'h0);
    check("rst_b_busy",  {31'b0, b_busy}, 32'h0);
    check("rst_b_rdata", b_rdata,         32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: sel, we, addr, wdata, be, expected err, expected rdata
    add(0, 1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'h0);
    add(0, 0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 32'h20,       32'h11223344, 4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 32'h20,       32'hAABBCCDD, 4'h5, 0, 32'hDEADBEEF);
    add(0, 0, 32'h20,       32'h0,        4'hF, 0, 32'h11BB33DD);
    add(0, 1, 32'h00,       32'hCAFEF00D, 4'hF, 0, 32'h11BB33DD);
    add(0, 0, 32'h22,       32'h0,        4'hF, 1, 32'h0);
    add(0, 1, 32'h400,      32'h01020304, 4'hF, 1, 32'h0);
    add(0, 0, 32'h00,       32'h0,        4'hF, 0, 32'hCAFEF00D);
    add(0, 1, 32'h10,       32'hFFFFFFFF, 4'h0, 0, 32'hCAFEF00D);
    add(0, 0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF);
    add(0, 1, 32'h3FC,      32'h12345678, 4'hF, 0, 32'hDEADBEEF);
    add(0, 0, 32'h3FC,      32'h0,        4'hF, 0, 32'h12345678);
    add(0, 0, 32'h400,      32'h0,        4'hF, 1, 32'h0);
    add(0, 1, 32'h13,       32'h77777777, 4'hF, 1, 32'h0);
    add(0, 0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF);
    add(0, 0, 32'hFFFFFFFC, 32'h0,        4'hF, 1, 32'h0);
    add(0, 0, 32'h10,       32'h0,        4'h0, 0, 32'hDEADBEEF);
    add(1, 1, 32'h1000,     32'hA5A5A5A5, 4'hF, 0, 32'h0);
    add(1, 0, 32'h0FFC,     32'h0,        4'hF, 1, 32'h0);
    add(1, 0, 32'h1000,     32'h0,        4'hF, 0, 32'hA5A5A5A5);
    add(1, 1, 32'h1400,     32'h99999999, 4'hF, 1, 32'h0);
    add(1, 1, 32'h13FC,     32'h0F0F0F0F, 4'hF, 0, 32'h0);
    add(1, 0, 32'h13FC,     32'h0,        4'hF, 0, 32'h0F0F0F0F);
    add(1, 0, 32'h0000,     32'h0,        4'hF, 1, 32'h0);

    foreach (vt[i]) begin
      txn(vt[i].sel, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, err, rd, lat);
      model_step(vt[i].sel, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, e_err, e_rd, e_k);
      check($sformatf("vec%0d_lat", i), lat, vt[i].sel ? LAT_B : LAT_A);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].exp_err});
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
    end

    // Reset while a store is in flight: the store must never land.
    run_model(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, "pre_rst_st");
    run_model(1'b0, 1'b0, 32'h30, 32'h0,        4'hF, "pre_rst_ld");
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h00000055, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("midrst_busy_before", {31'b0, a_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack",   {31'b0, a_ack},  32'h0);
    check("midrst_busy",  {31'b0, a_busy}, 32'h0);
    check("midrst_err",   {31'b0, a_err},  32'h0);
    check("midrst_rdata", a_rdata,         32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("postrst_no_ack", {31'b0, a_ack}, 32'h0);
    txn(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, err, rd, lat);
    model_step(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, e_err, e_rd, e_k);
    check("postrst_ld_rdata", rd, 32'h0BADF00D);
    check("postrst_ld_err", {31'b0, err}, 32'h0);

    // Back-to-back loads with req held high: acks in cycles 3, 6, 9.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        check("b2b_busy_k0", {31'b0, a_busy}, 32'h1);
        a_addr = 32'h20;
      end
      if (k == 2) check("b2b_busy_k2", {31'b0, a_busy}, 32'h0);
      if (k == 3) a_addr = 32'h00;
      if (k == 6) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (a_ack) begin
        ack_k.push_back(k + 1);
        ack_d.push_back(a_rdata);
      end
    end
    check("b2b_nacks", ack_k.size(), 32'd3);
    check("b2b_ack0_cycle", (ack_k.size() > 0) ? ack_k[0] : -1, 32'd3);
    check("b2b_ack1_cycle", (ack_k.size() > 1) ? ack_k[1] : -1, 32'd6);
    check("b2b_ack2_cycle", (ack_k.size() > 2) ? ack_k[2] : -1, 32'd9);
    check("b2b_ack0_rdata", (ack_d.size() > 0) ? ack_d[0] : 32'hX, 32'hDEADBEEF);
    check("b2b_ack1_rdata", (ack_d.size() > 1) ? ack_d[1] : 32'hX, 32'h11BB33DD);
    check("b2b_ack2_rdata", (ack_d.size() > 2) ? ack_d[2] : 32'hX, 32'hCAFEF00D);
    mdl_rd[0] = 32'hCAFEF00D; mdl_rdk[0] = 1'b1;

    // A request pulsed while busy is dropped: exactly one ack results.
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    @(posedge clk); #1;
    check("drop_busy", {31'b0, a_busy}, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    nacks = 0;
    rd = 32'h0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (a_ack) begin
        nacks++;
        rd = a_rdata;
      end
    end
    check("drop_nacks", nacks, 32'd1);
    check("drop_rdata", rd, 32'h11BB33DD);
    mdl_rd[0] = 32'h11BB33DD; mdl_rdk[0] = 1'b1;

    // LATENCY=1: store, then a load issued in the store's ack cycle.
    drive(1'b1, 1'b1, 1'b1, 32'h1040, 32'h13579BDF, 4'hF);
    @(posedge clk); #1;
    check("l1_st_ack",  {31'b0, b_ack},  32'h1);
    check("l1_st_err",  {31'b0, b_err},  32'h0);
    check("l1_st_busy", {31'b0, b_busy}, 32'h0);
    b_we = 1'b0;
    @(posedge clk); #1;
    check("l1_ld_ack",   {31'b0, b_ack}, 32'h1);
    check("l1_ld_rdata", b_rdata,        32'h13579BDF);
    check("l1_ld_err",   {31'b0, b_err}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("l1_ack_gone", {31'b0, b_ack}, 32'h0);
    model_step(1'b1, 1'b1, 32'h1040, 32'h13579BDF, 4'hF, e_err, e_rd, e_k);
    model_step(1'b1, 1'b0, 32'h1040, 32'h0,        4'hF, e_err, e_rd, e_k);

    // Randomized traffic against the model on both instances.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        run_model(s[0], 1'b1, (s == 1 ? 32'h1000 : 32'h0) + 32'(i * 4), $urandom, 4'hF,
                  $sformatf("fill%0d_%0d", s, i));
      end
    end
    for (int n = 0; n < 80; n++) begin
      bit sel;
      logic [31:0] addr, base;
      int r;
      sel  = 1'($urandom_range(1, 0));
      base = sel ? 32'h1000 : 32'h0;
      r    = int'($urandom_range(7, 0));
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = base + 32'($urandom_range(15, 0) * 4) + 32'($urandom_range(3, 1));
      else if (r == 2) addr = base + 32'($urandom_range(300, 0) * 4);
      else             addr = base + 32'($urandom_range(15, 0) * 4);
      run_model(sel, 1'($urandom_range(1, 0)), addr, $urandom, 4'($urandom_range(15, 0)),
                $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
